// File: rtl/int_issue_queue_pkg.sv
// Shared dispatcher definitions: default widths, control-bit layout, RV32 opcodes
// and the default-width issue queue entry layout.
package int_issue_queue_pkg;

  localparam int unsigned IqTagW  = 6;
  localparam int unsigned IqDataW = 32;
  localparam int unsigned IqCtrlW = 4;

  // Bit positions inside the 4-bit {jmp, branch, jalr, reg_write} control field
  localparam int unsigned CtrlRegWrite = 0;
  localparam int unsigned CtrlJalr     = 1;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlJmp      = 3;

  // RV32 base opcodes routed to the integer queue
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  // Entry layout at the default widths; the queue itself builds the same layout
  // from its own TAG_W/DATA_W parameters so it stays width-generic.
  typedef struct packed {
    logic               valid;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [IqCtrlW-1:0] ctrl;
    logic [IqDataW-1:0] imm;
    logic [IqDataW-1:0] pc;
    logic [IqTagW-1:0]  rd_tag;
    logic               rs1_rdy;
    logic [IqTagW-1:0]  rs1_tag;
    logic [IqDataW-1:0] rs1_data;
    logic               rs2_rdy;
    logic [IqTagW-1:0]  rs2_tag;
    logic [IqDataW-1:0] rs2_data;
  } iq_entry_t;

endpackage

// File: rtl/int_issue_queue_select.sv
// Lowest-index priority encoder: picks the oldest ready entry of the collapsing queue.
module int_issue_queue_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic found;

  // Scan from index 0 upward; the first requester wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: collapsing, age-ordered (entry 0 oldest). Holds decoded
// instructions until both operands are available, snoops the CDB for producer
// tags and issues the oldest ready entry to the integer execution unit.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = IqTagW,
  parameter int unsigned DATA_W = IqDataW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               disp_en,
  input  logic [6:0]         disp_opcode,
  input  logic [2:0]         disp_funct3,
  input  logic [6:0]         disp_funct7,
  input  logic [3:0]         disp_ctrl,
  input  logic [DATA_W-1:0]  disp_imm,
  input  logic [DATA_W-1:0]  disp_pc,
  input  logic [TAG_W-1:0]   disp_rd_tag,
  input  logic               disp_rs1_rdy,
  input  logic [TAG_W-1:0]   disp_rs1_tag,
  input  logic [DATA_W-1:0]  disp_rs1_data,
  input  logic               disp_rs2_rdy,
  input  logic [TAG_W-1:0]   disp_rs2_tag,
  input  logic [DATA_W-1:0]  disp_rs2_data,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_data,
  output logic               iq_full,
  output logic               iq_empty,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [6:0]         issue_opcode,
  output logic [2:0]         issue_funct3,
  output logic [6:0]         issue_funct7,
  output logic [3:0]         issue_ctrl,
  output logic [DATA_W-1:0]  issue_imm,
  output logic [DATA_W-1:0]  issue_pc,
  output logic [TAG_W-1:0]   issue_rd_tag,
  output logic [DATA_W-1:0]  issue_rs1_data,
  output logic [DATA_W-1:0]  issue_rs2_data
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic               valid;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [IqCtrlW-1:0] ctrl;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  pc;
    logic [TAG_W-1:0]   rd_tag;
    logic               rs1_rdy;
    logic [TAG_W-1:0]   rs1_tag;
    logic [DATA_W-1:0]  rs1_data;
    logic               rs2_rdy;
    logic [TAG_W-1:0]   rs2_tag;
    logic [DATA_W-1:0]  rs2_data;
  } entry_t;

  entry_t          ent_q   [DEPTH];
  entry_t          ent_d   [DEPTH];
  entry_t          woke    [DEPTH];
  entry_t          shifted [DEPTH];
  entry_t          new_ent;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] wr_ptr;
  logic            full_q, full_d;
  logic            empty_q, empty_d;

  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] gnt;
  logic [DEPTH-1:0] shift_mask;
  logic [IdxW-1:0]  sel_idx;
  logic             sel_any;
  logic             issue_fire;
  logic             accept;

  // Ready vector from registered state only; a wakeup is visible one cycle later
  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = ent_q[i].valid & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
    end
  end

  int_issue_queue_select #(
    .N    (DEPTH),
    .IdxW (IdxW)
  ) u_iq_select (
    .req_i (req),
    .gnt_o (gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  assign issue_fire = sel_any & issue_ready;
  // iq_full is the registered flag, so a same-cycle issue never makes room early
  assign accept     = disp_en & ~full_q;

  assign issue_valid    = sel_any;
  assign issue_opcode   = ent_q[sel_idx].opcode;
  assign issue_funct3   = ent_q[sel_idx].funct3;
  assign issue_funct7   = ent_q[sel_idx].funct7;
  assign issue_ctrl     = ent_q[sel_idx].ctrl;
  assign issue_imm      = ent_q[sel_idx].imm;
  assign issue_pc       = ent_q[sel_idx].pc;
  assign issue_rd_tag   = ent_q[sel_idx].rd_tag;
  assign issue_rs1_data = ent_q[sel_idx].rs1_data;
  assign issue_rs2_data = ent_q[sel_idx].rs2_data;
  assign iq_full        = full_q;
  assign iq_empty       = empty_q;

  // Next-state: CDB wakeup, collapse above the issued slot, append at the tail
  always_comb begin
    logic run;

    // Wakeup of waiting operands in every valid entry
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].valid && !ent_q[i].rs1_rdy && cdb_valid && (cdb_tag == ent_q[i].rs1_tag)) begin
        woke[i].rs1_rdy  = 1'b1;
        woke[i].rs1_data = cdb_data;
      end
      if (ent_q[i].valid && !ent_q[i].rs2_rdy && cdb_valid && (cdb_tag == ent_q[i].rs2_tag)) begin
        woke[i].rs2_rdy  = 1'b1;
        woke[i].rs2_data = cdb_data;
      end
    end

    // Every slot at or above the granted one takes its upper neighbour
    run = 1'b0;
    shift_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      run           = run | gnt[i];
      shift_mask[i] = run & issue_fire;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woke[i + 1];
    end
    shifted[DEPTH-1] = '0;

    // Incoming entry, with same-cycle CDB bypass for operands still pending
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.opcode   = disp_opcode;
    new_ent.funct3   = disp_funct3;
    new_ent.funct7   = disp_funct7;
    new_ent.ctrl     = disp_ctrl;
    new_ent.imm      = disp_imm;
    new_ent.pc       = disp_pc;
    new_ent.rd_tag   = disp_rd_tag;
    new_ent.rs1_rdy  = disp_rs1_rdy;
    new_ent.rs1_tag  = disp_rs1_tag;
    new_ent.rs1_data = disp_rs1_data;
    new_ent.rs2_rdy  = disp_rs2_rdy;
    new_ent.rs2_tag  = disp_rs2_tag;
    new_ent.rs2_data = disp_rs2_data;
    if (!disp_rs1_rdy && cdb_valid && (cdb_tag == disp_rs1_tag)) begin
      new_ent.rs1_rdy  = 1'b1;
      new_ent.rs1_data = cdb_data;
    end
    if (!disp_rs2_rdy && cdb_valid && (cdb_tag == disp_rs2_tag)) begin
      new_ent.rs2_rdy  = 1'b1;
      new_ent.rs2_data = cdb_data;
    end

    // Tail position after the issue collapse
    wr_ptr = cnt_q - CntW'(issue_fire);

    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = shift_mask[i] ? shifted[i] : woke[i];
      if (accept && (CntW'(i) == wr_ptr)) begin
        ent_d[i] = new_ent;
      end
      if (flush) begin
        ent_d[i] = '0;
      end
    end

    cnt_d = cnt_q + CntW'(accept) - CntW'(issue_fire);
    if (flush) begin
      cnt_d = '0;
    end
    full_d  = (cnt_d == CntW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue: an age-ordered list model predicts status
// and issued instructions; a negedge monitor compares them against the DUT.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 6;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst, flush, disp_en;
  logic [6:0]    disp_opcode, disp_funct7;
  logic [2:0]    disp_funct3;
  logic [3:0]    disp_ctrl;
  logic [DW-1:0] disp_imm, disp_pc, disp_rs1_data, disp_rs2_data;
  logic [TW-1:0] disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
  logic          disp_rs1_rdy, disp_rs2_rdy;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic          iq_full, iq_empty, issue_ready, issue_valid;
  logic [6:0]    issue_opcode, issue_funct7;
  logic [2:0]    issue_funct3;
  logic [3:0]    issue_ctrl;
  logic [DW-1:0] issue_imm, issue_pc, issue_rs1_data, issue_rs2_data;
  logic [TW-1:0] issue_rd_tag;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_en(disp_en),
    .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_ctrl(disp_ctrl), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_rd_tag(disp_rd_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iq_full(iq_full), .iq_empty(iq_empty), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_ctrl(issue_ctrl), .issue_imm(issue_imm),
    .issue_pc(issue_pc), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data)
  );

  typedef struct {
    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [3:0]    ctrl;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [TW-1:0] rd;
    bit            r1;
    logic [TW-1:0] t1;
    logic [DW-1:0] d1;
    bit            r2;
    logic [TW-1:0] t2;
    logic [DW-1:0] d2;
  } ment_t;

  typedef logic [154:0] iss_t;
  typedef struct packed {
    logic iv;
    logic full;
    logic empty;
  } st_t;

  ment_t mq[$];
  iss_t  exp_iss[$];
  st_t   exp_st[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  st_t   mon_s;
  iss_t  act_iss;

  assign act_iss = {issue_opcode, issue_funct3, issue_funct7, issue_ctrl, issue_imm, issue_pc,
                    issue_rd_tag, issue_rs1_data, issue_rs2_data};

  function automatic iss_t pack_ent(ment_t e);
    return {e.opcode, e.f3, e.f7, e.ctrl, e.imm, e.pc, e.rd, e.d1, e.d2};
  endfunction

  function automatic void chk(string name, logic [159:0] act, logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: mid-cycle compare of status every cycle and of fields on each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_st.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL status_queue: got no expectation, required one per cycle");
      end else begin
        mon_s = exp_st.pop_front();
        chk("issue_valid", issue_valid, mon_s.iv);
        chk("iq_full", iq_full, mon_s.full);
        chk("iq_empty", iq_empty, mon_s.empty);
      end
      if (issue_valid && issue_ready && !flush) begin
        if (exp_iss.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL issue_unexpected: got issue of pc %h, required no issue", issue_pc);
        end else begin
          chk("issue_fields", act_iss, exp_iss.pop_front());
        end
      end
    end
  end

  // Reference model step: record expectations for this cycle, then advance one clock
  task automatic step();
    st_t   s;
    ment_t e;
    int    sel;
    bit    acc;
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    end
    s.iv    = (sel >= 0);
    s.full  = (mq.size() == DEPTH);
    s.empty = (mq.size() == 0);
    exp_st.push_back(s);
    acc = disp_en && (mq.size() < DEPTH);
    if (flush) begin
      mq.delete();
    end else begin
      if (sel >= 0 && issue_ready) begin
        exp_iss.push_back(pack_ent(mq[sel]));
        mq.delete(sel);
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin
          mq[i].r1 = 1'b1;
          mq[i].d1 = cdb_data;
        end
        if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin
          mq[i].r2 = 1'b1;
          mq[i].d2 = cdb_data;
        end
      end
      if (acc) begin
        e.opcode = disp_opcode; e.f3 = disp_funct3; e.f7 = disp_funct7; e.ctrl = disp_ctrl;
        e.imm = disp_imm; e.pc = disp_pc; e.rd = disp_rd_tag;
        e.r1 = disp_rs1_rdy; e.t1 = disp_rs1_tag; e.d1 = disp_rs1_data;
        e.r2 = disp_rs2_rdy; e.t2 = disp_rs2_tag; e.d2 = disp_rs2_data;
        if (!e.r1 && cdb_valid && e.t1 == cdb_tag) begin
          e.r1 = 1'b1;
          e.d1 = cdb_data;
        end
        if (!e.r2 && cdb_valid && e.t2 == cdb_tag) begin
          e.r2 = 1'b1;
          e.d2 = cdb_data;
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_en     = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
    issue_ready = 1'b0;
  endtask

  task automatic set_disp(input bit r1, input logic [TW-1:0] t1, input bit r2,
                          input logic [TW-1:0] t2);
    disp_en = 1'b1;
    case ($urandom_range(0, 6))
      0: disp_opcode = OpcOp;
      1: disp_opcode = OpcOpImm;
      2: disp_opcode = OpcLui;
      3: disp_opcode = OpcAuipc;
      4: disp_opcode = OpcBranch;
      5: disp_opcode = OpcJal;
      default: disp_opcode = OpcJalr;
    endcase
    disp_funct3   = 3'($urandom);
    disp_funct7   = 7'($urandom);
    disp_ctrl     = 4'($urandom);
    disp_imm      = $urandom;
    disp_pc       = $urandom;
    disp_rd_tag   = TW'($urandom);
    disp_rs1_rdy  = r1;
    disp_rs1_tag  = t1;
    disp_rs1_data = $urandom;
    disp_rs2_rdy  = r2;
    disp_rs2_tag  = t2;
    disp_rs2_data = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_disp(1'b1, '0, 1'b1, '0);
    disp_en = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: fill to full, fifth dispatch dropped
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, '0, 1'b1, '0);
      step();
    end
    chk("t1_full", iq_full, 1'b1);
    set_disp(1'b1, '0, 1'b1, '0);
    step();
    idle();
    chk("t1_full_hold", iq_full, 1'b1);
    issue_ready = 1'b1;
    repeat (5) step();
    chk("t1_drained", iq_empty, 1'b1);

    // 2: younger ready entry bypasses an older waiting one; wakeup then issue
    idle();
    set_disp(1'b0, TW'(5), 1'b1, '0);
    step();
    set_disp(1'b1, '0, 1'b1, '0);
    step();
    idle();
    issue_ready = 1'b1;
    step();
    cdb_valid = 1'b1;
    cdb_tag = TW'(5);
    cdb_data = 32'hDEAD;
    step();
    idle();
    issue_ready = 1'b1;
    chk("t2_wake_valid", issue_valid, 1'b1);
    chk("t2_rs1_data", issue_rs1_data, 32'hDEAD);
    step();

    // 3: dispatch-time CDB bypass
    idle();
    set_disp(1'b1, '0, 1'b0, TW'(9));
    cdb_valid = 1'b1;
    cdb_tag = TW'(9);
    cdb_data = 32'h1234;
    step();
    idle();
    chk("t3_valid", issue_valid, 1'b1);
    chk("t3_rs2_data", issue_rs2_data, 32'h1234);
    issue_ready = 1'b1;
    step();
    chk("t3_empty", iq_empty, 1'b1);

    // 4: full queue, issue and dispatch together
    idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(1'b1, '0, 1'b1, '0);
      step();
    end
    idle();
    issue_ready = 1'b1;
    set_disp(1'b1, '0, 1'b1, '0);
    step();
    chk("t4_not_full", iq_full, 1'b0);
    chk("t4_not_empty", iq_empty, 1'b0);
    idle();
    issue_ready = 1'b1;
    repeat (3) step();
    chk("t4_empty", iq_empty, 1'b1);

    // 5: flush beats a same-cycle dispatch
    idle();
    for (int i = 0; i < 3; i++) begin
      set_disp(1'b1, '0, 1'b1, '0);
      step();
    end
    set_disp(1'b1, '0, 1'b1, '0);
    flush = 1'b1;
    issue_ready = 1'b1;
    step();
    idle();
    chk("t5_empty", iq_empty, 1'b1);
    chk("t5_issue_valid", issue_valid, 1'b0);
    chk("t5_full", iq_full, 1'b0);

    // 6: one broadcast wakes two waiters; they issue oldest first
    set_disp(1'b0, TW'(7), 1'b1, '0);
    step();
    set_disp(1'b0, TW'(7), 1'b1, '0);
    step();
    idle();
    cdb_valid = 1'b1;
    cdb_tag = TW'(7);
    cdb_data = $urandom;
    step();
    idle();
    issue_ready = 1'b1;
    chk("t6_valid", issue_valid, 1'b1);
    step();
    step();
    chk("t6_empty", iq_empty, 1'b1);

    // Random traffic
    repeat (3000) begin
      set_disp($urandom_range(0, 2) != 0, TW'($urandom_range(0, 7)),
               $urandom_range(0, 2) != 0, TW'($urandom_range(0, 7)));
      disp_en     = ($urandom_range(0, 9) < 6);
      cdb_valid   = $urandom_range(0, 1) == 1;
      cdb_tag     = TW'($urandom_range(0, 7));
      cdb_data    = $urandom;
      issue_ready = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      step();
    end

    idle();
    flush = 1'b1;
    step();
    idle();
    step();
    mon_en = 1'b0;
    chk("pending_issues", exp_iss.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
